pipelined_multiplier: RTL and testbench
=======================================

// Module: pipelined_multiplier
// PURPOSE
//  Parametrised, pipelined RV32M multiplier for the MUL execution unit (MUL/MULH/MULHSU/MULHU).
//  Accepts one op per cycle and returns its result after a fixed LATENCY, with valid/ready handshakes.
//  Each op carries its rrf destination tag and speculative tag. Ops are killed on branch mispredict.
//  Speculative tags are cleared on branch success.
//  Sits between the MUL reservation station (issue side) and the CDB arbiter (result side).
// PARAMETERS
//  DATA_LEN    32  operand/result width
//  LATENCY     3   issue-to-result cycles when not stalled; legal range 2..8
//  RRF_SEL     6   width of rrf destination tag
//  SPECTAG_LEN 5   width of one-hot speculative tag / mask
// PORTS
//  clk           in   1            clock, rising edge
//  reset_x       in   1            asynchronous active-low reset
//  in_valid      in   1            op presented
//  in_ready      out  1            unit can accept op this cycle
//  src1, src2    in   DATA_LEN     operands
//  src1_signed   in   1            treat src1 as signed
//  src2_signed   in   1            treat src2 as signed
//  sel_lohi      in   1            0: low DATA_LEN bits of product, 1: high DATA_LEN bits
//  in_rrftag     in   RRF_SEL      destination tag
//  in_spectag    in   SPECTAG_LEN  op's speculative tag mask
//  prmiss        in   1            branch mispredict this cycle
//  prsuccess     in   1            branch resolved correct this cycle
//  spectag_fix   in   SPECTAG_LEN  tag of resolving branch (one-hot)
//  kill_mask     in   SPECTAG_LEN  on prmiss: kill any op with (spectag & kill_mask) != 0
//  out_valid     out  1            result valid
//  out_ready     in   1            CDB accepts result
//  result        out  DATA_LEN     selected product half
//  out_rrftag    out  RRF_SEL      tag of result
//  out_spectag   out  SPECTAG_LEN  current spectag of result op
// BEHAVIOUR
//  - Reset (reset_x=0, async): all stage valids=0, out_valid=0, result=0, out_rrftag=0, out_spectag=0.
//    Reset mid-operation discards all in-flight ops.
//  - Pipeline: LATENCY register stages; stage k holds valid, tag, spectag, sel_lohi and partial data.
//  - Arithmetic: each operand is extended to DATA_LEN+1 bits (sign-extend if *_signed, else zero-extend).
//    Signed (DATA_LEN+1)x(DATA_LEN+1) product; bits [2*DATA_LEN-1:0] kept.
//    result = sel_lohi ? prod[2*DATA_LEN-1:DATA_LEN] : prod[DATA_LEN-1:0].
//    Product partitioning across stages is free, but the result must match this bit-exactly.
//  - Handshake:
//    - Accept when in_valid && in_ready.
//    - Emit when out_valid && out_ready.
//    - stall = out_valid && !out_ready. On stall the whole pipe holds.
//    - in_ready = !stall. No bubble collapsing.
//    - out_valid/result/tags stay stable while stalled.
//  - Latency: an op accepted in cycle N with no stall is out_valid in cycle N+LATENCY.
//    Throughput is 1 op/cycle.
//  - prmiss: same-cycle kill of every stage (including output stage) whose spectag & kill_mask != 0.
//    - Killed valid bits are 0 next cycle.
//    - An accepting op with in_spectag & kill_mask != 0 is not accepted (enters invalid).
//    - Killed output: out_valid drops next cycle even if stalled; the handshake that cycle still counts if out_ready=1.
//  - prsuccess: clear spectag_fix bits from every stage's spectag and from the incoming op's spectag.
//  - prmiss and prsuccess in the same cycle: kill first; survivors get spectag_fix cleared.
//  - Stall and kill in the same cycle: the kill applies; valid bits held by the stall are still cleared.
//  - No combinational path in_valid->out_valid.
//    in_ready depends only on out_valid register and out_ready.
// TESTING
//  - MUL/MULH/MULHSU/MULHU, src1=0xFFFFFFFF, src2=0x00000002:
//    -> lo 0xFFFFFFFE; hi ss 0xFFFFFFFF, su 0xFFFFFFFF, uu 0x00000001; us (src1 unsigned, src2 signed) 0x00000001.
//  - Back-to-back 8 ops, out_ready=1, LATENCY=3:
//    -> results in order on 8 consecutive cycles, first 3 cycles after first accept.
//  - out_ready=0 for 4 cycles with pipe full:
//    -> in_ready=0, outputs stable; on release, no op lost or duplicated.
//  - Stage spectags 00001/00010/00100, prmiss kill_mask=00110:
//    -> only the 00001 op emerges, all tags correct.
//  - prsuccess spectag_fix=00010 on an in-flight op with 00011:
//    -> op emerges with out_spectag=00001.
//  - Assert reset_x low while 3 ops are in flight:
//    -> out_valid=0 immediately; after release, the first new op's result is correct at LATENCY.

Source files
------------

// File: rtl/pipelined_multiplier.sv
// pipelined_multiplier: LATENCY-stage RV32M multiplier for the MUL execution unit.
// Stage 0 latches extended operands, stage 1 forms the product, later stages carry it.
module pipelined_multiplier #(
  parameter int DATA_LEN    = 32,
  parameter int LATENCY     = 3,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset_x,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LEN-1:0]    src1,
  input  logic [DATA_LEN-1:0]    src2,
  input  logic                   src1_signed,
  input  logic                   src2_signed,
  input  logic                   sel_lohi,
  input  logic [RRF_SEL-1:0]     in_rrftag,
  input  logic [SPECTAG_LEN-1:0] in_spectag,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] spectag_fix,
  input  logic [SPECTAG_LEN-1:0] kill_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LEN-1:0]    result,
  output logic [RRF_SEL-1:0]     out_rrftag,
  output logic [SPECTAG_LEN-1:0] out_spectag
);

  localparam int XW = DATA_LEN + 1;
  localparam int PW = 2 * DATA_LEN;
  localparam int LS = LATENCY - 1;

  logic [LATENCY-1:0]     vld_q;
  logic [LATENCY-1:0]     lohi_q;
  logic [RRF_SEL-1:0]     tag_q  [LATENCY];
  logic [SPECTAG_LEN-1:0] spec_q [LATENCY];
  logic [XW-1:0]          a_q;
  logic [XW-1:0]          b_q;
  logic [PW-1:0]          prod_q [LATENCY-1];

  logic                   stall;
  logic                   in_kill;
  logic [LATENCY-1:0]     kill;
  logic [SPECTAG_LEN-1:0] keep_mask;
  logic [XW-1:0]          a_ext;
  logic [XW-1:0]          b_ext;
  logic [PW-1:0]          a_wide;
  logic [PW-1:0]          b_wide;
  logic [PW-1:0]          prod;

  assign stall     = vld_q[LS] & ~out_ready;
  assign in_ready  = ~stall;
  assign in_kill   = prmiss & |(in_spectag & kill_mask);
  assign keep_mask = prsuccess ? ~spectag_fix : '1;

  assign a_ext = {src1_signed & src1[DATA_LEN-1], src1};
  assign b_ext = {src2_signed & src2[DATA_LEN-1], src2};

  // Sign-extending to PW makes a plain PW-bit multiply give the low PW product bits
  assign a_wide = {{(PW-XW){a_q[XW-1]}}, a_q};
  assign b_wide = {{(PW-XW){b_q[XW-1]}}, b_q};
  assign prod   = a_wide * b_wide;

  always_comb begin
    kill = '0;
    for (int k = 0; k < LATENCY; k++) begin
      kill[k] = prmiss & |(spec_q[k] & kill_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      vld_q  <= '0;
      lohi_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k]  <= '0;
        spec_q[k] <= '0;
      end
      for (int k = 0; k < LATENCY - 1; k++) begin
        prod_q[k] <= '0;
      end
    end else if (stall) begin
      // Held stages still lose killed ops and resolved tag bits
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k]  <= vld_q[k] & ~kill[k];
        spec_q[k] <= spec_q[k] & keep_mask;
      end
    end else begin
      vld_q[0]  <= in_valid & ~in_kill;
      lohi_q[0] <= sel_lohi;
      tag_q[0]  <= in_rrftag;
      spec_q[0] <= in_spectag & keep_mask;
      a_q       <= a_ext;
      b_q       <= b_ext;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k]  <= vld_q[k-1] & ~kill[k-1];
        lohi_q[k] <= lohi_q[k-1];
        tag_q[k]  <= tag_q[k-1];
        spec_q[k] <= spec_q[k-1] & keep_mask;
      end
      prod_q[0] <= prod;
      for (int k = 1; k < LATENCY - 1; k++) begin
        prod_q[k] <= prod_q[k-1];
      end
    end
  end

  assign out_valid   = vld_q[LS];
  assign out_rrftag  = tag_q[LS];
  assign out_spectag = spec_q[LS];
  assign result      = lohi_q[LS] ? prod_q[LS-1][PW-1:DATA_LEN]
                                  : prod_q[LS-1][DATA_LEN-1:0];

endmodule

// File: tb/tb_pipelined_multiplier.sv
// tb_pipelined_multiplier: randomized and directed checks of pipelined_multiplier
// against a queue-based reference model of accepted, unkilled ops.
module tb_pipelined_multiplier;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset_x = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        src1_signed = 1'b0;
  logic        src2_signed = 1'b0;
  logic        sel_lohi = 1'b0;
  logic [5:0]  in_rrftag = '0;
  logic [4:0]  in_spectag = '0;
  logic        prmiss = 1'b0;
  logic        prsuccess = 1'b0;
  logic [4:0]  spectag_fix = '0;
  logic [4:0]  kill_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [5:0]  out_rrftag;
  logic [4:0]  out_spectag;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [4:0]  spec;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  pipelined_multiplier #(
    .DATA_LEN(32), .LATENCY(L), .RRF_SEL(6), .SPECTAG_LEN(5)
  ) dut (
    .clk(clk), .reset_x(reset_x),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2),
    .src1_signed(src1_signed), .src2_signed(src2_signed),
    .sel_lohi(sel_lohi), .in_rrftag(in_rrftag), .in_spectag(in_spectag),
    .prmiss(prmiss), .prsuccess(prsuccess),
    .spectag_fix(spectag_fix), .kill_mask(kill_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_rrftag(out_rrftag), .out_spectag(out_spectag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s1, input logic s2, input logic hi);
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] p;
    ax = s1 ? {{32{a[31]}}, a} : {32'h0, a};
    bx = s2 ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ax * bx;
    return hi ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] exp_now();
    return ref_mul(src1, src2, src1_signed, src2_signed, sel_lohi);
  endfunction

  // Scoreboard: ops leave in order; kills and tag clears act on the in-flight set
  always @(negedge clk) begin
    if (!reset_x) begin
      q.delete();
    end else if (mon_en) begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious: got res=%h tag=%0d, expected no op", result, out_rrftag);
        end else begin
          mon_e = q.pop_front();
          if ({result, out_rrftag, out_spectag} !== {mon_e.res, mon_e.tag, mon_e.spec}) begin
            errors++;
            $display("FAIL sb_result: got res=%h tag=%0d spec=%b, expected res=%h tag=%0d spec=%b",
                     result, out_rrftag, out_spectag, mon_e.res, mon_e.tag, mon_e.spec);
          end
        end
      end
      if (prmiss) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if ((q[i].spec & kill_mask) != 0) q.delete(i);
        end
      end
      if (prsuccess) begin
        for (int i = 0; i < q.size(); i++) begin
          mon_e = q[i];
          mon_e.spec = mon_e.spec & ~spectag_fix;
          q[i] = mon_e;
        end
      end
      if (in_valid && in_ready && !(prmiss && (in_spectag & kill_mask) != 0)) begin
        mon_e.res  = exp_now();
        mon_e.tag  = in_rrftag;
        mon_e.spec = prsuccess ? (in_spectag & ~spectag_fix) : in_spectag;
        q.push_back(mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; prmiss = 1'b0; prsuccess = 1'b0;
    spectag_fix = '0; kill_mask = '0; in_spectag = '0;
    out_ready = 1'b1;
  endtask

  task automatic rand_op(input logic [5:0] tag, input logic [4:0] spec);
    in_valid    = 1'b1;
    src1        = $urandom;
    src2        = $urandom;
    src1_signed = 1'($urandom_range(0, 1));
    src2_signed = 1'($urandom_range(0, 1));
    sel_lohi    = 1'($urandom_range(0, 1));
    in_rrftag   = tag;
    in_spectag  = spec;
  endtask

  task automatic test_reset();
    reset_x = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, expected 0", result); end
    checks++; if (out_rrftag !== 6'h0) begin errors++; $display("FAIL reset_tag: got %h, expected 0", out_rrftag); end
    checks++; if (out_spectag !== 5'h0) begin errors++; $display("FAIL reset_spec: got %b, expected 0", out_spectag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", in_ready); end
    reset_x = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [34:0] cv [6];
    cv[0] = {1'b1, 1'b1, 1'b0, 32'hFFFFFFFE};
    cv[1] = {1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
    cv[2] = {1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    cv[3] = {1'b0, 1'b0, 1'b1, 32'h00000001};
    cv[4] = {1'b0, 1'b1, 1'b1, 32'h00000001};
    cv[5] = {1'b0, 1'b0, 1'b0, 32'hFFFFFFFE};
    for (int i = 0; i < 6; i++) begin
      in_valid    = 1'b1;
      src1        = 32'hFFFFFFFF;
      src2        = 32'h00000002;
      src1_signed = cv[i][34];
      src2_signed = cv[i][33];
      sel_lohi    = cv[i][32];
      in_rrftag   = 6'(i + 1);
      in_spectag  = '0;
      tick();
      in_valid = 1'b0;
      repeat (L - 2) tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL dir_early_%0d: out_valid=%b, expected 0", i, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== cv[i][31:0] || out_rrftag !== 6'(i + 1)) begin
        errors++;
        $display("FAIL dir_op_%0d: valid=%b res=%h tag=%0d, expected 1 %h %0d",
                 i, out_valid, result, out_rrftag, cv[i][31:0], i + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea [8];
    for (int c = 0; c <= L + 8; c++) begin
      if (c == L - 1 || c == L + 8) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_c%0d: out_valid=%b, expected 0", c, out_valid);
        end
      end else if (c >= L && c < L + 8) begin
        checks++;
        if (out_valid !== 1'b1 || result !== ea[c-L] || out_rrftag !== 6'(32 + c - L)) begin
          errors++;
          $display("FAIL b2b_out_%0d: valid=%b res=%h tag=%0d, expected 1 %h %0d",
                   c - L, out_valid, result, out_rrftag, ea[c-L], 32 + c - L);
        end
      end
      if (c < 8) begin
        rand_op(6'(32 + c), '0);
        ea[c] = exp_now();
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_res;
    logic [5:0]  h_tag;
    int          n;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) begin
        h_res = result;
        h_tag = out_rrftag;
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_full: out_valid=%b, expected 1", out_valid);
        end
      end
      if (c >= 6 && c <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || result !== h_res || out_rrftag !== h_tag || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold_c%0d: valid=%b res=%h tag=%0d rdy=%b, expected 1 %h %0d 0",
                   c, out_valid, result, out_rrftag, in_ready, h_res, h_tag);
        end
      end
      rand_op(6'(c), '0);
      out_ready = (c >= 5 && c <= 8) ? 1'b0 : 1'b1;
      if (c == 5) begin
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_ready: in_ready=%b, expected 0", in_ready);
        end
      end
      tick();
    end
    idle();
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: %0d ops left, out_valid=%b, expected 0 0", q.size(), out_valid);
    end
  endtask

  task automatic test_kill();
    logic [31:0] e0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_rrftag !== 6'd10 || out_spectag !== 5'b00001 || result !== e0) begin
          errors++;
          $display("FAIL kill_survivor: valid=%b tag=%0d spec=%b res=%h, expected 1 10 00001 %h",
                   out_valid, out_rrftag, out_spectag, result, e0);
        end
      end else if (c > 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL kill_gone_c%0d: out_valid=%b tag=%0d, expected 0", c, out_valid, out_rrftag);
        end
      end
      idle();
      if (c == 0) begin rand_op(6'd10, 5'b00001); e0 = exp_now(); end
      if (c == 1) rand_op(6'd11, 5'b00010);
      if (c == 2) rand_op(6'd12, 5'b00100);
      if (c == 3) begin
        rand_op(6'd13, 5'b00010);
        prmiss    = 1'b1;
        kill_mask = 5'b00110;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_kill_stalled();
    rand_op(6'd20, 5'b00010);
    tick();
    in_valid = 1'b0;
    repeat (L - 1) tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_rrftag !== 6'd20) begin
      errors++; $display("FAIL kstall_held: valid=%b tag=%0d, expected 1 20", out_valid, out_rrftag);
    end
    prmiss    = 1'b1;
    kill_mask = 5'b01010;
    tick();
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL kstall_drop: out_valid=%b, expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_prsuccess();
    rand_op(6'd30, 5'b00011);
    tick();
    in_valid    = 1'b0;
    prsuccess   = 1'b1;
    spectag_fix = 5'b00010;
    tick();
    idle();
    repeat (L - 2) tick();
    checks++;
    if (out_valid !== 1'b1 || out_rrftag !== 6'd30 || out_spectag !== 5'b00001) begin
      errors++;
      $display("FAIL prsucc: valid=%b tag=%0d spec=%b, expected 1 30 00001", out_valid, out_rrftag, out_spectag);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    logic [31:0] e;
    int          n;
    for (int c = 0; c < 3; c++) begin
      rand_op(6'(40 + c), '0);
      tick();
    end
    idle();
    reset_x = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: out_valid=%b, expected 0", out_valid);
    end
    tick();
    reset_x = 1'b1;
    tick();
    rand_op(6'd50, '0);
    e = exp_now();
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != L || out_rrftag !== 6'd50 || result !== e) begin
      errors++;
      $display("FAIL rst_new_op: latency=%0d tag=%0d res=%h, expected %0d 50 %h", n, out_rrftag, result, L, e);
    end
    tick();
  endtask

  task automatic test_random();
    int n;
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0) rand_op(6'($urandom), 5'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        prmiss    = 1'b1;
        kill_mask = 5'(1 << $urandom_range(0, 4));
      end
      if ($urandom_range(0, 5) == 0) begin
        prsuccess   = 1'b1;
        spectag_fix = 5'(1 << $urandom_range(0, 4));
      end
      tick();
    end
    idle();
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drain: %0d ops left, out_valid=%b, expected 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_kill();
    test_kill_stalled();
    test_prsuccess();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
